// File: rtl/eth_rx_frame_checker_if.sv
// Bundle between a GMII-style receive byte source and eth_rx_frame_checker.
// Latency: none, this is wiring only.
// Backpressure: none, the byte stream runs at one byte per clock.
// Ports: dv/er/data come from the source. out_* is the framed DA..payload stream.
//        stat_* is the per-frame status. good_cnt/bad_cnt are the frame counters.
interface eth_rx_frame_checker_if;
  logic        dv;
  logic        er;
  logic [7:0]  data;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_sof;
  logic        out_eof;
  logic        stat_valid;
  logic        stat_good;
  logic        stat_crc_err;
  logic        stat_len_err;
  logic        stat_phy_err;
  logic        stat_pre_err;
  logic [10:0] stat_len;
  logic [1:0]  stat_dst_port;
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;

  // Source side: drives the receive bytes and observes the checker results.
  modport master (
    output dv, er, data,
    input  out_valid, out_data, out_sof, out_eof,
    input  stat_valid, stat_good, stat_crc_err, stat_len_err, stat_phy_err,
    input  stat_pre_err, stat_len, stat_dst_port, good_cnt, bad_cnt
  );

  // Checker side.
  modport slave (
    input  dv, er, data,
    output out_valid, out_data, out_sof, out_eof,
    output stat_valid, stat_good, stat_crc_err, stat_len_err, stat_phy_err,
    output stat_pre_err, stat_len, stat_dst_port, good_cnt, bad_cnt
  );
endinterface

// File: rtl/eth_rx_frame_checker.sv
// Receive frame checker: strips preamble/SFD/FCS, forwards DA..payload, emits one status strobe per frame.
// Latency: DA byte k appears on out_data one cycle after byte k+5 is sampled; status arrives on the edge sampling dv=0.
// Backpressure: none; accepts one byte per clock and never stalls.
// Ports: clk/rst_n are scalar. rx (slave modport) carries dv/er/data in and the out_*, stat_* and counter outputs.
module eth_rx_frame_checker #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic                   clk,
  input  logic                   rst_n,
  eth_rx_frame_checker_if.slave  rx
);

  localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     r_crc;
  logic [10:0]     r_cnt;
  logic [4:0][7:0] r_dly;      // [0] newest, [4] oldest
  logic [1:0]      r_dst;
  logic            r_phy;

  logic [31:0]     w_crc_nxt;
  logic            w_crc_bad;
  logic            w_len_bad;
  logic            w_line_full;

  // Non-reflected CRC register, byte fed LSB first (bit-reversed input).
  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
      else              c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (rx.dv) w_state_nxt = (rx.data == 8'h55) ? S_PRE : S_DROP;
      S_PRE: begin
        if (!rx.dv)                w_state_nxt = S_IDLE;
        else if (rx.data == 8'hD5) w_state_nxt = S_DATA;
        else if (rx.data != 8'h55) w_state_nxt = S_DROP;
      end
      S_DATA: if (!rx.dv) w_state_nxt = S_IDLE;
      S_DROP: if (!rx.dv) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_crc_nxt   = crc_step(r_crc, rx.data);
    w_crc_bad   = (r_crc != CRC_RESIDUE);
    w_len_bad   = (r_cnt < 11'(MIN_LEN)) || (r_cnt > 11'(MAX_LEN));
    // Once five bytes are held, the oldest one cannot be FCS and is forwarded.
    w_line_full = (r_cnt >= 11'd5);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc            <= '0;
      r_cnt            <= '0;
      r_dly            <= '0;
      r_dst            <= '0;
      r_phy            <= 1'b0;
      rx.out_valid     <= 1'b0;
      rx.out_data      <= '0;
      rx.out_sof       <= 1'b0;
      rx.out_eof       <= 1'b0;
      rx.stat_valid    <= 1'b0;
      rx.stat_good     <= 1'b0;
      rx.stat_crc_err  <= 1'b0;
      rx.stat_len_err  <= 1'b0;
      rx.stat_phy_err  <= 1'b0;
      rx.stat_pre_err  <= 1'b0;
      rx.stat_len      <= '0;
      rx.stat_dst_port <= '0;
      rx.good_cnt      <= '0;
      rx.bad_cnt       <= '0;
    end else begin
      rx.out_valid  <= 1'b0;
      rx.out_sof    <= 1'b0;
      rx.out_eof    <= 1'b0;
      rx.stat_valid <= 1'b0;
      case (r_state)
        S_PRE: begin
          if (rx.dv && rx.data == 8'hD5) begin
            r_crc <= 32'hFFFF_FFFF;
            r_cnt <= '0;
            r_dst <= '0;
            r_phy <= 1'b0;
          end
        end
        S_DATA: begin
          if (rx.dv) begin
            r_dly <= {r_dly[3:0], rx.data};
            r_crc <= w_crc_nxt;
            if (r_cnt != 11'h7FF) r_cnt <= r_cnt + 11'd1;
            // Six bytes in means this is the last DA byte.
            if (r_cnt == 11'd5) r_dst <= rx.data[1:0];
            r_phy <= r_phy | rx.er;
            if (w_line_full) begin
              rx.out_valid <= 1'b1;
              rx.out_data  <= r_dly[4];
              rx.out_sof   <= (r_cnt == 11'd5);
            end
          end else begin
            // End of frame: oldest held byte is the last payload byte, the rest is FCS.
            if (w_line_full) begin
              rx.out_valid <= 1'b1;
              rx.out_data  <= r_dly[4];
              rx.out_sof   <= (r_cnt == 11'd5);
              rx.out_eof   <= 1'b1;
            end
            rx.stat_valid    <= 1'b1;
            rx.stat_good     <= !w_crc_bad && !w_len_bad && !r_phy;
            rx.stat_crc_err  <= w_crc_bad;
            rx.stat_len_err  <= w_len_bad;
            rx.stat_phy_err  <= r_phy;
            rx.stat_pre_err  <= 1'b0;
            rx.stat_len      <= r_cnt;
            rx.stat_dst_port <= r_dst;
            if (!w_crc_bad && !w_len_bad && !r_phy) rx.good_cnt <= rx.good_cnt + 16'd1;
            else                                    rx.bad_cnt  <= rx.bad_cnt + 16'd1;
          end
        end
        S_DROP: begin
          if (!rx.dv) begin
            rx.stat_valid    <= 1'b1;
            rx.stat_good     <= 1'b0;
            rx.stat_crc_err  <= 1'b0;
            rx.stat_len_err  <= 1'b0;
            rx.stat_phy_err  <= 1'b0;
            rx.stat_pre_err  <= 1'b1;
            rx.stat_len      <= '0;
            rx.stat_dst_port <= '0;
            rx.bad_cnt       <= rx.bad_cnt + 16'd1;
          end
        end
        default: ;
      endcase
      // A preamble that stops before SFD is reported the same way as a dropped one.
      if (r_state == S_PRE && !rx.dv) begin
        rx.stat_valid    <= 1'b1;
        rx.stat_good     <= 1'b0;
        rx.stat_crc_err  <= 1'b0;
        rx.stat_len_err  <= 1'b0;
        rx.stat_phy_err  <= 1'b0;
        rx.stat_pre_err  <= 1'b1;
        rx.stat_len      <= '0;
        rx.stat_dst_port <= '0;
        rx.bad_cnt       <= rx.bad_cnt + 16'd1;
      end
    end
  end

endmodule
